div_seq: RTL and testbench

- Iterative signed integer divider; the inverse operation of the team's combinational signed multiplier.
- Used where a datapath must undo a scaling product, e.g. normalising an accumulated product back to sample width.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with a valid/ready handshake on both sides.
- Result semantics match Verilog signed "/" and "%": truncation toward zero, and the remainder takes the sign of the dividend.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 131 +++++++++++++
 tb/tb_div_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Operand and result handshake bundle for the sequential signed divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface div_seq_if #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH_N-1:0] dividend;
    logic signed [WIDTH_D-1:0] divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH_N-1:0] quotient;
    logic signed [WIDTH_D-1:0] remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq.sv
// Iterative signed divider: restoring radix-2 on magnitudes, one quotient bit per clock,
// signs applied afterwards so results truncate toward zero like Verilog "/" and "%".
module div_seq #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    div_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH_N);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic                 sign_quo_q, sign_quo_d;
    logic                 sign_rem_q, sign_rem_d;
    logic [WIDTH_N-1:0]   mag_n_q, mag_n_d;
    logic [WIDTH_D:0]     mag_d_q, mag_d_d;
    logic [WIDTH_D:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH_N-1:0]   quotient_q, quotient_d;
    logic [WIDTH_D-1:0]   remainder_q, remainder_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH_N-1:0]   dvd_u;
    logic [WIDTH_N-1:0]   dvd_abs;
    logic [WIDTH_D:0]     dvs_ext;
    logic [WIDTH_D:0]     dvs_abs;
    logic [WIDTH_D:0]     shifted;

    // Divisor magnitude needs one extra bit so that the most negative divisor is representable.
    assign dvd_u   = bus.dividend;
    assign dvd_abs = bus.dividend[WIDTH_N-1] ? ({WIDTH_N{1'b0}} - dvd_u) : dvd_u;
    assign dvs_ext = {bus.divisor[WIDTH_D-1], bus.divisor};
    assign dvs_abs = bus.divisor[WIDTH_D-1] ? ({(WIDTH_D+1){1'b0}} - dvs_ext) : dvs_ext;
    assign shifted = {rem_q[WIDTH_D-1:0], mag_n_q[WIDTH_N-1]};

    always_comb begin
        state_d     = state_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        mag_n_d     = mag_n_q;
        mag_d_d     = mag_d_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend[WIDTH_D-1:0];
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        sign_quo_d = bus.dividend[WIDTH_N-1] ^ bus.divisor[WIDTH_D-1];
                        sign_rem_d = bus.dividend[WIDTH_N-1];
                        mag_n_d    = dvd_abs;
                        mag_d_d    = dvs_abs;
                        rem_d      = '0;
                        cnt_d      = CNT_W'(WIDTH_N - 1);
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                // Dividend bits leave mag_n at the top while quotient bits enter at the bottom.
                if (shifted >= mag_d_q) begin
                    rem_d   = shifted - mag_d_q;
                    mag_n_d = {mag_n_q[WIDTH_N-2:0], 1'b1};
                end else begin
                    rem_d   = shifted;
                    mag_n_d = {mag_n_q[WIDTH_N-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = sign_quo_q ? ({WIDTH_N{1'b0}} - mag_n_q) : mag_n_q;
                remainder_d = WIDTH_D'(sign_rem_q ? ({(WIDTH_D+1){1'b0}} - rem_q) : rem_q);
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            mag_n_q     <= '0;
            mag_d_q     <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            mag_n_q     <= mag_n_d;
            mag_d_q     <= mag_d_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, backpressure, mid-operation reset
// and a random sweep compared against Verilog "/" and "%" on plain integers.
module tb_div_seq;
    localparam int WN = 16;
    localparam int WD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH_N(WN), .WIDTH_D(WD)) bus ();

    div_seq #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: integer division on 32-bit ints, then wrapped to port widths.
    function automatic void refModel(input logic signed [WN-1:0] a, input logic signed [WD-1:0] b,
                                     output logic [WN-1:0] q, output logic [WD-1:0] r,
                                     output logic z);
        int ai;
        int bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            q = '1;
            r = a[WD-1:0];
            z = 1'b1;
        end else begin
            q = WN'(ai / bi);
            r = WD'(ai % bi);
            z = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WN-1:0] eq, input logic [WD-1:0] er,
                               input logic ez);
        checkOutput({tag, "/out_valid"}, bus.out_valid, 1);
        checkOutput({tag, "/quotient"}, $unsigned(bus.quotient), eq);
        checkOutput({tag, "/remainder"}, $unsigned(bus.remainder), er);
        checkOutput({tag, "/div_by_zero"}, bus.div_by_zero, ez);
    endtask

    task automatic applyStimulus(input logic signed [WN-1:0] a, input logic signed [WD-1:0] b);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_wait", bus.in_ready, 1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output bit rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "/out_valid_after"}, bus.out_valid, 0);
        checkOutput({tag, "/in_ready_after"}, bus.in_ready, 1);
    endtask

    task automatic runVector(input string tag, input logic signed [WN-1:0] a,
                             input logic signed [WD-1:0] b, input int stall);
        logic [WN-1:0] eq;
        logic [WD-1:0] er;
        logic          ez;
        int            lat;
        bit            rdy;
        logic [31:0]   rnd;
        refModel(a, b, eq, er, ez);
        applyStimulus(a, b);
        waitResult(lat, rdy);
        checkOutput({tag, "/latency"}, lat, ez ? 0 : WN + 1);
        checkOutput({tag, "/in_ready_busy"}, rdy, 0);
        checkResult(tag, eq, er, ez);
        for (int i = 0; i < stall; i++) begin
            rnd          = $urandom;
            bus.dividend = rnd[31:16];
            bus.divisor  = rnd[7:0];
            bus.in_valid = 1'b1;
            @(negedge clk);
            checkResult({tag, "/stall"}, eq, er, ez);
        end
        releaseResult(tag);
    endtask

    initial begin
        logic signed [WN-1:0] a;
        logic signed [WD-1:0] b;
        logic [31:0]          rnd;
        bit                   seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        $display("[TB] reset checks");
        repeat (2) @(negedge clk);
        checkOutput("rst/in_ready", bus.in_ready, 1);
        checkOutput("rst/out_valid", bus.out_valid, 0);
        checkOutput("rst/quotient", $unsigned(bus.quotient), 0);
        checkOutput("rst/remainder", $unsigned(bus.remainder), 0);
        checkOutput("rst/div_by_zero", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        runVector("100/7", 16'sd100, 8'sd7, 0);
        runVector("-100/7", -16'sd100, 8'sd7, 0);
        runVector("100/-7", 16'sd100, -8'sd7, 0);
        runVector("-100/-7", -16'sd100, -8'sd7, 0);
        runVector("min/-1", 16'sh8000, -8'sd1, 0);
        runVector("max/min", 16'sd32767, 8'sh80, 0);
        runVector("5/0", 16'sd5, 8'sd0, 0);
        runVector("6/3", 16'sd6, 8'sd3, 0);

        $display("[TB] backpressure");
        runVector("bp", 16'sd1234, -8'sd9, 10);

        $display("[TB] reset during calculation");
        applyStimulus(16'sd1000, 8'sd3);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst/in_ready", bus.in_ready, 1);
        checkOutput("midrst/out_valid", bus.out_valid, 0);
        checkOutput("midrst/quotient", $unsigned(bus.quotient), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checkOutput("midrst/no_output", seen, 0);
        runVector("after_rst", 16'sd1000, 8'sd3, 0);

        $display("[TB] random sweep");
        for (int n = 0; n < 1000; n++) begin
            rnd = $urandom;
            a   = ($urandom_range(0, 19) == 0) ? 16'sh8000 : rnd[31:16];
            case ($urandom_range(0, 9))
                0:       b = 8'sd0;
                1:       b = -8'sd1;
                2:       b = 8'sh80;
                default: b = rnd[7:0];
            endcase
            runVector("rand", a, b, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
